// File: rtl/icache_pkg.sv
// icache_pkg: shared types, constants and helpers for the instruction cache refill path
package icache_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} refill_state_t;
  localparam int BEAT_BYTES = 8;
  localparam int DEF_B = 64;
  localparam int BEATS = DEF_B / BEAT_BYTES;
  function automatic logic [63:0] block_align(input logic [63:0] addr, input int b);
    return addr & ~((64'd1 << $clog2(b)) - 64'd1);
  endfunction
endpackage

// File: rtl/instr_cache_refill_ctrl.sv
// instr_cache_refill_ctrl: on an icache miss, fetch one block from L2 and stream its beats into the missing set
module instr_cache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int B = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cache_miss,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              l2_req_valid,
  input  logic              l2_req_ready,
  output logic [ADDR_W-1:0] l2_req_addr,
  input  logic              l2_rsp_valid,
  input  logic [63:0]       l2_rsp_data,
  output logic              rep_enable,
  output logic [63:0]       rep_word,
  output logic              stall,
  output logic              refill_done,
  output logic [31:0]       miss_count
);
  localparam int NB = B / BEAT_BYTES;
  localparam int CW = $clog2(NB);
  if (B % BEAT_BYTES != 0 || B < 16) begin : g_bad_b
    $error("instr_cache_refill_ctrl: B must be a multiple of 8 and at least 16");
  end
  refill_state_t state, next;
  logic [CW-1:0] beat_cnt;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] count;
  logic beat, last;
  assign last = beat_cnt == CW'(NB - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beat_cnt <= '0;
      req_addr <= '0;
      count <= '0;
    end else begin
      state <= next;
      if (state == IDLE && cache_miss) begin
        req_addr <= ADDR_W'(block_align(64'(fetch_addr), B));
        beat_cnt <= '0;
        count <= count + 32'(count != '1);
      end
      if (beat) beat_cnt <= last ? '0 : beat_cnt + CW'(1);
    end
  end
  // beats are written straight through; reset suppresses any write in its own cycle
  always_comb begin
    beat = state == FILL && l2_rsp_valid && !reset;
    next = state;
    l2_req_valid = 1'b0;
    refill_done = 1'b0;
    unique case (state)
      IDLE: next = cache_miss ? REQ : IDLE;
      REQ: begin
        l2_req_valid = 1'b1;
        next = l2_req_ready ? FILL : REQ;
      end
      FILL: next = beat && last ? DONE : FILL;
      DONE: begin
        refill_done = 1'b1;
        next = IDLE;
      end
    endcase
  end
  assign l2_req_addr = req_addr;
  assign rep_enable = beat;
  assign rep_word = state == FILL ? l2_rsp_data : 64'd0;
  assign stall = cache_miss | state == REQ | state == FILL;
  assign miss_count = count;
endmodule
